// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: instruction format codes, opcodes and the
// immediate ranges each format can represent.
package rv_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2,
    FMT_J = 2'd3
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMMB_MIN  = -4096;
  localparam int signed IMMB_MAX  = 4094;
  localparam int signed IMMJ_MIN  = -1048576;
  localparam int signed IMMJ_MAX  = 1048574;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input int signed lo,
                                    input int signed hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: register fields plus signed immediate -> RV32I word,
// with a flag saying whether the immediate fits the selected format.
module imm_pack
  import rv_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  logic signed [31:0] simm;
  assign simm = imm;

  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    case (fmt_e'(fmt))
      FMT_I: begin
        word     = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok = in_range(simm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_ok = in_range(simm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_ok = in_range(simm, IMMB_MIN, IMMB_MAX) && !imm[0];
      end
      FMT_J: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_ok = in_range(simm, IMMJ_MIN, IMMJ_MAX) && !imm[0];
      end
      default: begin
        word     = '0;
        range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Boot/test program loader: encodes requests into RV32I words and streams them
// into instruction memory through a registered, auto-incrementing write port.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [31:0]       imm,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_fmt
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [31:0]       word;
  logic              range_ok;
  logic              accept;

  imm_pack u_imm_pack (
    .fmt      (fmt),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .imm      (imm),
    .word     (word),
    .range_ok (range_ok)
  );

  assign in_ready  = !full && !err && !load_base;
  assign accept    = in_valid && in_ready;
  assign count_nxt = count + 1'b1;

  // wr_ptr wraps naturally at 2^ADDR_W; full is tracked separately against DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
      err_fmt    <= '0;
    end else begin
      imem_we <= 1'b0;
      if (load_base) begin
        wr_ptr <= base_addr;
        count  <= '0;
        full   <= 1'b0;
        err    <= 1'b0;
      end else if (accept) begin
        if (range_ok) begin
          imem_we    <= 1'b1;
          imem_addr  <= wr_ptr;
          imem_wdata <= word;
          wr_ptr     <= wr_ptr + 1'b1;
          count      <= count_nxt;
          full       <= (count_nxt == DEPTH_W);
        end else begin
          err     <= 1'b1;
          err_fmt <= fmt;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed check of instr_encoder against a field-arithmetic
// reference model of the encoding, range rules, address counter and flags.
module tb_instr_encoder;

  localparam int AW  = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [31:0]   imm;
  logic          load_base;
  logic [AW-1:0] base_addr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  logic [1:0]    err_fmt;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .imm        (imm),
    .load_base  (load_base),
    .base_addr  (base_addr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .err_fmt    (err_fmt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  int          m_ptr, m_count, m_addr;
  bit          m_full, m_err, m_we;
  logic [1:0]  m_efmt;
  logic [31:0] m_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [1:0] f, input logic [31:0] im);
    int signed s;
    s = signed'(im);
    case (f)
      2'd0, 2'd1: return (s >= -2048) && (s <= 2047);
      2'd2:       return (s >= -4096) && (s <= 4094) && (im[0] == 1'b0);
      default:    return (s >= -1048576) && (s <= 1048574) && (im[0] == 1'b0);
    endcase
  endfunction

  // Encoding expressed as shifts and masks of the immediate value.
  function automatic logic [31:0] enc(input logic [1:0] f, input logic [31:0] op,
                                      input logic [31:0] d, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] f3,
                                      input logic [31:0] u);
    case (f)
      2'd0: return ((u & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      2'd1: return (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                   | ((u & 32'h1F) << 7) | op;
      2'd2: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (s2 << 20)
                   | (s1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                   | (((u >> 11) & 32'h1) << 7) | op;
      default: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                      | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                      | (d << 7) | op;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_count = 0; m_addr = 0; m_full = 0; m_err = 0; m_we = 0;
    m_efmt = 2'd0; m_wdata = 32'd0;
  endtask

  task automatic check_outputs();
    chk("we", imem_we, m_we);
    chk("addr", imem_addr, m_addr);
    chk("wdata", imem_wdata, m_wdata);
    chk("count", count, m_count);
    chk("full", full, m_full);
    chk("err", err, m_err);
    chk("err_fmt", err_fmt, m_efmt);
  endtask

  // One clock: drive request, check in_ready, advance model, check registered outputs.
  task automatic cycle(input logic v, input logic [1:0] f, input logic [6:0] op,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] f3, input logic [31:0] im,
                       input logic lb, input logic [AW-1:0] base);
    bit rdy;
    in_valid = v; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3;
    imm = im; load_base = lb; base_addr = base;
    #1;
    rdy = !m_full && !m_err && !lb;
    chk("in_ready", in_ready, rdy);
    m_we = 0;
    if (lb) begin
      m_ptr = base; m_count = 0; m_full = 0; m_err = 0;
    end else if (v && rdy) begin
      if (legal(f, im)) begin
        m_we = 1; m_addr = m_ptr;
        m_wdata = enc(f, 32'(op), 32'(d), 32'(s1), 32'(s2), 32'(f3), im);
        m_ptr = (m_ptr + 1) % (1 << AW);
        m_count++;
        m_full = (m_count == DEP);
      end else begin
        m_err = 1; m_efmt = f;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic reload(input logic [AW-1:0] base);
    cycle(1'b0, 2'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b1, base);
  endtask

  function automatic logic [31:0] pick_imm(input logic [1:0] f);
    int lim, r, v;
    lim = (f < 2) ? 2048 : (f == 2) ? 4096 : 1048576;
    r = int'($urandom_range(0, 9));
    case (r)
      0: v = lim;
      1: v = -lim;
      2: v = lim - 1;
      3: v = -lim - 2;
      4: v = int'($urandom_range(0, 2 * lim - 1)) - lim;
      default: begin
        v = int'($urandom_range(0, 2 * lim - 1)) - lim;
        if (f >= 2) v = v & ~1;
      end
    endcase
    return 32'(v);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 0; fmt = 0; opcode = 0; rd = 0; rs1 = 0; rs2 = 0;
    funct3 = 0; imm = 0; load_base = 0; base_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed encodes, back to back
    reload(2'd0);
    cycle(1, 2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 0, 0);
    chk("I_word", imem_wdata, 32'h00500093);
    cycle(1, 2'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 0, 0);
    chk("S_word", imem_wdata, 32'h0020A423);
    cycle(1, 2'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 0, 0);
    cycle(1, 2'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, 0, 0);
    chk("J_word", imem_wdata, 32'h008000EF);
    chk("J_addr", imem_addr, 2'd3);

    // Range error, held request, recovery
    reload(2'd0);
    cycle(1, 2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 0, 0);
    chk("I2048_err", err, 1'b1);
    repeat (2) cycle(1, 2'd2, 7'h63, 5'd3, 5'd4, 5'd5, 3'd1, 32'd6, 0, 0);
    cycle(1, 2'd2, 7'h63, 5'd3, 5'd4, 5'd5, 3'd1, 32'd6, 1, 2'd1);
    cycle(1, 2'd2, 7'h63, 5'd3, 5'd4, 5'd5, 3'd1, 32'd6, 0, 0);
    chk("reload_addr", imem_addr, 2'd1);
    cycle(1, 2'd2, 7'h63, 5'd3, 5'd4, 5'd5, 3'd1, 32'd3, 0, 0);
    chk("B_odd_err", err, 1'b1);
    reload(2'd0);
    cycle(1, 2'd3, 7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1048576, 0, 0);
    chk("J_range_fmt", err_fmt, 2'd3);

    // Full and address wrap
    reload(2'd2);
    for (int i = 0; i < 5; i++)
      cycle(1, 2'd0, 7'h13, 5'(i), 5'd7, 5'd0, 3'd0, 32'(i), 0, 0);
    chk("wrap_count", count, 3'd4);
    chk("wrap_full", full, 1'b1);

    // Reset between accept and its write edge
    reload(2'd1);
    in_valid = 1; fmt = 2'd0; opcode = 7'h13; rd = 5'd9; imm = 32'd100; load_base = 0;
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 2'd0, 7'h13, 5'd9, 5'd1, 5'd0, 3'd0, 32'd100, 0, 0);
    chk("post_reset_addr", imem_addr, 2'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] f;
      logic       lb;
      f = 2'($urandom_range(0, 3));
      if ((m_err || m_full) && $urandom_range(0, 3) == 0) lb = 1'b1;
      else lb = ($urandom_range(0, 30) == 0);
      cycle(($urandom_range(0, 3) != 0), f, 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 3'($urandom), pick_imm(f), lb, AW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
